dc_video2ram_f: RTL and testbench

Capture stage directly upstream of the HQ2X line-buffer reader. Takes the Dreamcast pixel stream (one pixel per `in_valid` strobe, framed by line/frame start pulses) and writes it into the shared dual-port line-buffer RAM in the ring layout the reader walks (`buffer_line_length` words per line, wrap at `ram_numwords`). Qualifies input frame stability and raises `starttrigger`, which releases the reader.

---
 rtl/dc_video2ram_f_pkg.sv | 22 ++
 rtl/dc_video2ram_f_frame_qualifier.sv | 68 ++++++
 rtl/dc_video2ram_f.sv | 102 ++++++++++
 tb/tb_dc_video2ram_f.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dc_video2ram_f_pkg.sv
// Shared video config plus the capture-stage FSM encoding and qualification defaults.
package dc_video2ram_f_pkg;

    localparam int ADDR_W = 14;
    localparam int LINE_CNT_W = 12;
    localparam logic [LINE_CNT_W-1:0] LINE_CNT_MAX = '1;

    localparam int STABLE_FRAMES_DEFAULT = 2;
    localparam int TRIGGER_LINE_DEFAULT = 2;
    localparam int VISIBLE_LINES_DEFAULT = 480;

    typedef struct packed {
        logic [ADDR_W-1:0] ram_numwords;
        logic [ADDR_W-1:0] buffer_line_length;
    } HDMIVideoConfig;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        CAPTURE    = 1'b1
    } cap_state_t;

endpackage

// File: rtl/dc_video2ram_f_frame_qualifier.sv
// Judges each captured frame on line count and line completeness, and raises the
// sticky reader start trigger once enough consecutive good frames have been seen.
module dc_video2ram_f_frame_qualifier
    import dc_video2ram_f_pkg::*;
#(
    parameter int STABLE_FRAMES = STABLE_FRAMES_DEFAULT,
    parameter int TRIGGER_LINE  = TRIGGER_LINE_DEFAULT,
    parameter int VISIBLE_LINES = VISIBLE_LINES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic frame_start,
    input  logic judge,
    input  logic line_start,
    input  logic line_short,
    input  logic overrun,
    output logic starttrigger,
    output logic sync_error
);

    localparam logic [LINE_CNT_W-1:0] VIS_LINES = LINE_CNT_W'(VISIBLE_LINES);
    localparam logic [LINE_CNT_W-1:0] TRIG_CNT  = LINE_CNT_W'(TRIGGER_LINE + 1);
    localparam logic [7:0]            STABLE_MIN = 8'(STABLE_FRAMES);

    logic [LINE_CNT_W-1:0] line_cnt, cnt_n;
    logic [7:0]            stable_cnt, stable_n;
    logic                  frame_ok, ok_n;
    logic                  armed, armed_n;
    logic                  good_frame;

    always_comb begin
        good_frame = (line_cnt == VIS_LINES) && frame_ok && !line_short;
        stable_n   = stable_cnt;
        if (judge)
            stable_n = good_frame ? ((stable_cnt == 8'hFF) ? stable_cnt : stable_cnt + 8'd1) : 8'd0;
        cnt_n   = frame_start ? '0 : line_cnt;
        ok_n    = frame_start ? 1'b1 : frame_ok;
        armed_n = frame_start ? (stable_n >= STABLE_MIN) : armed;
        if (line_start) begin
            // A short line coinciding with frame start belongs to the frame being judged.
            if (!frame_start && line_short)
                ok_n = 1'b0;
            if (cnt_n != LINE_CNT_MAX)
                cnt_n = cnt_n + 1'b1;
        end
        if (overrun)
            ok_n = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            line_cnt     <= '0;
            stable_cnt   <= '0;
            frame_ok     <= 1'b1;
            armed        <= 1'b0;
            starttrigger <= 1'b0;
            sync_error   <= 1'b0;
        end else begin
            line_cnt     <= cnt_n;
            stable_cnt   <= stable_n;
            frame_ok     <= ok_n;
            armed        <= armed_n;
            starttrigger <= starttrigger || (line_start && armed_n && (cnt_n == TRIG_CNT));
            sync_error   <= judge && !good_frame && starttrigger;
        end
    end

endmodule

// File: rtl/dc_video2ram_f.sv
// Writes the Dreamcast pixel stream into the HQ2X line-buffer ring and releases the
// reader once the incoming frames are qualified as stable.
module dc_video2ram_f
    import dc_video2ram_f_pkg::*;
#(
    parameter int STABLE_FRAMES = STABLE_FRAMES_DEFAULT,
    parameter int TRIGGER_LINE  = TRIGGER_LINE_DEFAULT,
    parameter int VISIBLE_LINES = VISIBLE_LINES_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  HDMIVideoConfig    hdmiVideoConfig,
    input  logic [23:0]       in_data,
    input  logic              in_valid,
    input  logic              in_line_start,
    input  logic              in_frame_start,
    output logic [ADDR_W-1:0] wraddr,
    output logic [23:0]       wrdata,
    output logic              wren,
    output logic              starttrigger,
    output logic              sync_error
);

    cap_state_t        state;
    logic [ADDR_W-1:0] line_base, x;
    logic              in_line, first_line;

    logic [ADDR_W-1:0] base_n, x_n, bll, wrap_thresh;
    logic              in_line_n, first_n;
    logic              active, line_start_evt, judge_evt, line_short, accept, overrun;

    assign bll            = hdmiVideoConfig.buffer_line_length;
    assign wrap_thresh    = hdmiVideoConfig.ram_numwords - bll;
    assign active         = (state == CAPTURE) || in_frame_start;
    assign line_start_evt = active && in_line_start;
    assign judge_evt      = (state == CAPTURE) && in_frame_start;
    assign line_short     = in_line && (x != bll);

    // Frame start is applied first so a coincident line start becomes line 0 at base 0.
    // NOTE: every always_comb output gets a default before any conditional update,
    // otherwise the synthesizer infers a latch to hold the unassigned case.
    always_comb begin
        base_n    = in_frame_start ? '0 : line_base;
        x_n       = in_frame_start ? '0 : x;
        in_line_n = in_frame_start ? 1'b0 : in_line;
        first_n   = in_frame_start ? 1'b1 : first_line;
        if (line_start_evt) begin
            if (!first_n)
                base_n = (base_n >= wrap_thresh) ? '0 : base_n + bll;
            x_n       = '0;
            in_line_n = 1'b1;
            first_n   = 1'b0;
        end
    end

    assign accept  = active && in_valid && in_line_n && (x_n < bll);
    assign overrun = active && in_valid && in_line_n && (x_n >= bll);

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= WAIT_FRAME;
            line_base  <= '0;
            x          <= '0;
            in_line    <= 1'b0;
            first_line <= 1'b1;
            wren       <= 1'b0;
            wraddr     <= '0;
            wrdata     <= '0;
        end else begin
            if (in_frame_start)
                state <= CAPTURE;
            line_base  <= base_n;
            x          <= accept ? x_n + 1'b1 : x_n;
            in_line    <= in_line_n;
            first_line <= first_n;
            wren       <= accept;
            if (accept) begin
                wraddr <= base_n + x_n;
                wrdata <= in_data;
            end
        end
    end

    dc_video2ram_f_frame_qualifier #(
        .STABLE_FRAMES (STABLE_FRAMES),
        .TRIGGER_LINE  (TRIGGER_LINE),
        .VISIBLE_LINES (VISIBLE_LINES)
    ) u_frame_qualifier (
        .clock        (clock),
        .reset        (reset),
        .frame_start  (in_frame_start),
        .judge        (judge_evt),
        .line_start   (line_start_evt),
        .line_short   (line_short),
        .overrun      (overrun),
        .starttrigger (starttrigger),
        .sync_error   (sync_error)
    );

endmodule

// File: tb/tb_dc_video2ram_f.sv
// Directed bench for dc_video2ram_f: scoreboarded RAM writes, trigger qualification,
// sync error pulse, coincident events and mid-line reset.
module tb_dc_video2ram_f;
    import dc_video2ram_f_pkg::*;

    localparam int VIS  = 26;
    localparam int BLL  = 64;
    localparam int RING = 23;
    localparam int NW   = RING * BLL;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    HDMIVideoConfig    cfg;
    logic [23:0]       in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_line_start = 1'b0;
    logic              in_frame_start = 1'b0;
    logic [ADDR_W-1:0] wraddr;
    logic [23:0]       wrdata;
    logic              wren;
    logic              starttrigger;
    logic              sync_error;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [23:0]       data;
    } wr_t;

    wr_t  exp_q[$];
    int   checks = 0;
    int   failures = 0;
    logic exp_trig = 1'b0;

    assign cfg.ram_numwords       = ADDR_W'(NW);
    assign cfg.buffer_line_length = ADDR_W'(BLL);

    always #5 clock = ~clock;

    dc_video2ram_f #(
        .STABLE_FRAMES (2),
        .TRIGGER_LINE  (2),
        .VISIBLE_LINES (VIS)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .hdmiVideoConfig (cfg),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_line_start   (in_line_start),
        .in_frame_start  (in_frame_start),
        .wraddr          (wraddr),
        .wrdata          (wrdata),
        .wren            (wren),
        .starttrigger    (starttrigger),
        .sync_error      (sync_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int f, input int l, input int x);
        return {8'(f * 37 + l), 8'(l), 8'(x)} ^ 24'h5A3C96;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_write(input int addr, input logic [23:0] data);
        wr_t w;
        w.addr = ADDR_W'(addr);
        w.data = data;
        exp_q.push_back(w);
    endtask

    // Scoreboard: every observed write must match the oldest expected one.
    always @(negedge clock) begin
        if (wren) begin
            check("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                wr_t w;
                w = exp_q.pop_front();
                check("wraddr", 32'(wraddr), 32'(w.addr));
                check("wrdata", 32'(wrdata), 32'(w.data));
            end
        end
    end

    task automatic send_line(input int f, input int l, input int npix, input bit armed);
        in_line_start = 1'b1;
        tick();
        in_line_start = 1'b0;
        if (armed && l >= 2)
            exp_trig = 1'b1;
        check($sformatf("trigger_f%0d_l%0d", f, l), 32'(starttrigger), 32'(exp_trig));
        for (int x = 0; x < npix; x++) begin
            in_valid = 1'b1;
            in_data  = pix(f, l, x);
            if (x < BLL)
                push_write((l % RING) * BLL + x, in_data);
            tick();
            if (l == RING && x == 0) begin
                check("wrap_wren", 32'(wren), 32'd1);
                check("wrap_addr", 32'(wraddr), 32'd0);
            end
        end
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_frame(input int f, input int nlines, input int overrun_line,
                              input bit armed, input bit exp_sync);
        check($sformatf("queue_drained_f%0d", f), 32'(exp_q.size()), 32'd0);
        in_frame_start = 1'b1;
        tick();
        in_frame_start = 1'b0;
        check($sformatf("sync_error_f%0d", f), 32'(sync_error), 32'(exp_sync));
        tick();
        check($sformatf("sync_error_clear_f%0d", f), 32'(sync_error), 32'd0);
        for (int l = 0; l < nlines; l++)
            send_line(f, l, (l == overrun_line) ? BLL + 6 : BLL, armed);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_wren", 32'(wren), 32'd0);
        check("rst_wraddr", 32'(wraddr), 32'd0);
        check("rst_wrdata", 32'(wrdata), 32'd0);
        check("rst_trigger", 32'(starttrigger), 32'd0);
        check("rst_sync_error", 32'(sync_error), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) tick();

        send_frame(0, VIS, -1, 1'b0, 1'b0);
        send_frame(1, VIS, 5, 1'b0, 1'b0);
        send_frame(2, VIS, -1, 1'b0, 1'b0);
        send_frame(3, VIS, -1, 1'b0, 1'b0);
        send_frame(4, VIS, -1, 1'b1, 1'b0);
        send_frame(5, VIS - 1, -1, 1'b1, 1'b0);
        check("queue_drained_f5", 32'(exp_q.size()), 32'd0);

        // Frame, line start and pixel together after a short frame with trigger high.
        in_frame_start = 1'b1;
        in_line_start  = 1'b1;
        in_valid       = 1'b1;
        in_data        = pix(6, 0, 0);
        push_write(0, in_data);
        tick();
        in_frame_start = 1'b0;
        in_line_start  = 1'b0;
        check("coincident_wren", 32'(wren), 32'd1);
        check("coincident_addr", 32'(wraddr), 32'd0);
        check("coincident_data", 32'(wrdata), 32'(pix(6, 0, 0)));
        check("short_frame_sync_error", 32'(sync_error), 32'd1);
        check("short_frame_trigger", 32'(starttrigger), 32'd1);
        for (int x = 1; x < 10; x++) begin
            in_data = pix(6, 0, x);
            push_write(x, in_data);
            tick();
            if (x == 1) begin
                check("sync_error_single_pulse", 32'(sync_error), 32'd0);
                check("trigger_held", 32'(starttrigger), 32'd1);
            end
        end

        // Mid-line reset.
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("midreset_wren", 32'(wren), 32'd0);
        check("midreset_trigger", 32'(starttrigger), 32'd0);
        tick();
        in_valid = 1'b0;
        check("midreset_wren_next", 32'(wren), 32'd0);
        check("midreset_trigger_next", 32'(starttrigger), 32'd0);
        check("midreset_queue", 32'(exp_q.size()), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        // Without a fresh frame start nothing is written.
        in_line_start = 1'b1;
        tick();
        in_line_start = 1'b0;
        for (int x = 0; x < 5; x++) begin
            in_valid = 1'b1;
            in_data  = pix(7, 0, x);
            tick();
            check("no_write_before_frame", 32'(wren), 32'd0);
        end
        in_valid = 1'b0;
        tick();

        in_frame_start = 1'b1;
        tick();
        in_frame_start = 1'b0;
        in_line_start = 1'b1;
        tick();
        in_line_start = 1'b0;
        for (int x = 0; x < 4; x++) begin
            in_valid = 1'b1;
            in_data  = pix(8, 0, x);
            push_write(x, in_data);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        check("final_queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_trigger_low", 32'(starttrigger), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
